v_writeback: RTL and testbench

//  Downstream of the SpMV datapath (final adder-tree stage, adder_out7). Takes one 24-bit row sum per
//  sum_valid pulse, buffers in a small FIFO, packs two sums per 48-bit word (matching v_sram word width),

---
 rtl/v_writeback.sv | 181 ++++++++++++++++++
 tb/tb_v_writeback.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v_writeback.sv
`default_nettype none
// ============================================================================
// Module   : v_writeback
// Purpose  : Result-vector writeback for the SpMV datapath. Accepts one 24-bit
//            row sum per sum_valid pulse, buffers it in a small FIFO, packs
//            two sums per 48-bit word and writes the words to consecutive
//            addresses of the result SRAM. Flags completion once the word
//            holding the last row sum has been accepted.
// Ports    : clock, reset          - rising-edge clock, async active-high reset
//            start                 - 1-cycle pulse, starts a new iteration
//            sum_valid, row_sum    - row sum from adder tree (no backpressure)
//            WriteGrant1           - SRAM accepts the pending write
//            WriteEnable1          - write request
//            WriteAddress1         - word address
//            WriteBus1             - {high sum, low sum}
//            rows_done             - sums accepted this iteration (saturating)
//            overflow              - sticky: a sum was dropped, FIFO full
//            done                  - sticky: last word accepted by SRAM
// Revision : 1.0 - initial release
// ============================================================================
module v_writeback #(
  parameter int NUM_ROWS   = 512,
  parameter int ADDR_W     = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              sum_valid,
  input  logic [23:0]       row_sum,
  input  logic              WriteGrant1,
  output logic              WriteEnable1,
  output logic [ADDR_W-1:0] WriteAddress1,
  output logic [47:0]       WriteBus1,
  output logic [9:0]        rows_done,
  output logic              overflow,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [9:0]        ROWS_MAX  = 10'(NUM_ROWS);
  // Word that carries sum index NUM_ROWS-1 (low half when NUM_ROWS is odd).
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'((NUM_ROWS - 1) / 2);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_PEND  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [23:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [23:0]       low_q, low_d;
  logic [23:0]       high_q, high_d;
  logic [ADDR_W-1:0] word_ptr_q, word_ptr_d;
  logic [9:0]        rows_q;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              ovf_q;

  logic fifo_full, fifo_empty;
  logic eligible, push, drop, pop;

  assign fifo_full  = (count_q == FIFO_FULL);
  assign fifo_empty = (count_q == '0);

  // Sums beyond NUM_ROWS in one iteration are not part of the vector and are
  // ignored; fullness is judged on the registered count, so a same-cycle pop
  // never makes room for a push.
  assign eligible = sum_valid && active_q && !done_q && (rows_q != ROWS_MAX);
  assign push     = eligible && !fifo_full;
  assign drop     = eligible && fifo_full;

  // Packer next-state and datapath
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    low_d      = low_q;
    high_d     = high_q;
    word_ptr_d = word_ptr_q;
    active_d   = active_q;
    done_d     = done_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          low_d   = fifo_mem[rd_ptr_q];
          state_d = ST_HALF;
        end
      end
      ST_HALF: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          high_d  = fifo_mem[rd_ptr_q];
          state_d = ST_PEND;
        end else if (rows_q == ROWS_MAX) begin
          // Odd row count: the final word carries only a low half.
          high_d  = '0;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (WriteGrant1) begin
          word_ptr_d = word_ptr_q + ADDR_W'(1);
          state_d    = ST_EMPTY;
          if (word_ptr_q == LAST_WORD) begin
            done_d   = 1'b1;
            active_d = 1'b0;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      low_q      <= '0;
      high_q     <= '0;
      word_ptr_q <= '0;
      rows_q     <= '0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (start) begin
      state_q    <= ST_EMPTY;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      low_q      <= '0;
      high_q     <= '0;
      word_ptr_q <= '0;
      rows_q     <= '0;
      active_q   <= 1'b1;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      low_q      <= low_d;
      high_q     <= high_d;
      word_ptr_q <= word_ptr_d;
      active_q   <= active_d;
      done_q     <= done_d;
      count_q    <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        rows_q   <= rows_q + 10'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clock) begin
    if (push && !start) begin
      fifo_mem[wr_ptr_q] <= row_sum;
    end
  end

  assign WriteEnable1  = (state_q == ST_PEND);
  assign WriteAddress1 = word_ptr_q;
  assign WriteBus1     = {high_q, low_q};
  assign rows_done     = rows_q;
  assign overflow      = ovf_q;
  assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_v_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_v_writeback
// Purpose  : Self-checking bench for v_writeback. Two instances share the
//            stimulus: instance 0 with NUM_ROWS=8, instance 1 with NUM_ROWS=3.
//            A queue/array reference model of the writeback behaviour is
//            compared against both instances every cycle, and directed
//            literal expectations pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_v_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        sum_valid;
  logic [23:0] row_sum;
  logic        WriteGrant1;

  logic [1:0]        we;
  logic [1:0][8:0]   addr;
  logic [1:0][47:0]  bus;
  logic [1:0][9:0]   rows;
  logic [1:0]        ovf;
  logic [1:0]        dn;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  v_writeback #(.NUM_ROWS(8), .ADDR_W(9), .FIFO_DEPTH(4)) u_dut_a (
    .clock(clock), .reset(reset), .start(start), .sum_valid(sum_valid),
    .row_sum(row_sum), .WriteGrant1(WriteGrant1), .WriteEnable1(we[0]),
    .WriteAddress1(addr[0]), .WriteBus1(bus[0]), .rows_done(rows[0]),
    .overflow(ovf[0]), .done(dn[0])
  );

  v_writeback #(.NUM_ROWS(3), .ADDR_W(9), .FIFO_DEPTH(4)) u_dut_b (
    .clock(clock), .reset(reset), .start(start), .sum_valid(sum_valid),
    .row_sum(row_sum), .WriteGrant1(WriteGrant1), .WriteEnable1(we[1]),
    .WriteAddress1(addr[1]), .WriteBus1(bus[1]), .rows_done(rows[1]),
    .overflow(ovf[1]), .done(dn[1])
  );

  // ---------------------------------------------------------------- model
  int          NR [2] = '{8, 3};
  logic [23:0] m_fifo [2][8];
  int          m_cnt  [2];
  int          m_held [2];   // sums sitting in the packer, not yet a word
  logic        m_pend [2];
  logic [23:0] m_lo   [2];
  logic [23:0] m_hi   [2];
  int          m_ptr  [2];
  int          m_rows [2];
  logic        m_act  [2];
  logic        m_done [2];
  logic        m_ovf  [2];

  task automatic model_clear(input int k, input logic act);
    m_cnt[k]  = 0;
    m_held[k] = 0;
    m_pend[k] = 1'b0;
    m_lo[k]   = '0;
    m_hi[k]   = '0;
    m_ptr[k]  = 0;
    m_rows[k] = 0;
    m_act[k]  = act;
    m_done[k] = 1'b0;
    m_ovf[k]  = 1'b0;
  endtask

  task automatic model_step(input int k);
    int          cnt;
    logic        elig;
    logic [23:0] head;
    cnt  = m_cnt[k];
    elig = sum_valid && m_act[k] && !m_done[k] && (m_rows[k] < NR[k]);
    if (m_pend[k]) begin
      if (WriteGrant1) begin
        if (m_ptr[k] == (NR[k] - 1) / 2) begin
          m_done[k] = 1'b1;
          m_act[k]  = 1'b0;
        end
        m_ptr[k]  = (m_ptr[k] + 1) % 512;
        m_pend[k] = 1'b0;
      end
    end else if (cnt > 0) begin
      head = m_fifo[k][0];
      for (int i = 0; i < 7; i++) m_fifo[k][i] = m_fifo[k][i+1];
      m_cnt[k] = m_cnt[k] - 1;
      if (m_held[k] == 0) begin
        m_lo[k]   = head;
        m_held[k] = 1;
      end else begin
        m_hi[k]   = head;
        m_held[k] = 0;
        m_pend[k] = 1'b1;
      end
    end else if (m_held[k] == 1 && m_rows[k] == NR[k]) begin
      m_hi[k]   = '0;
      m_held[k] = 0;
      m_pend[k] = 1'b1;
    end
    if (elig) begin
      if (cnt < 4) begin
        m_fifo[k][m_cnt[k]] = row_sum;
        m_cnt[k]  = m_cnt[k] + 1;
        m_rows[k] = m_rows[k] + 1;
      end else begin
        m_ovf[k] = 1'b1;
      end
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      model_clear(0, 1'b0);
      model_clear(1, 1'b0);
    end else if (start) begin
      model_clear(0, 1'b1);
      model_clear(1, 1'b1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------------------------------------------------------- checks
  task automatic cmp(input string nm, input int k, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", nm, k, got, exp, $time);
    end
  endtask

  logic [56:0] log_a [$];
  logic [56:0] log_b [$];

  // Per-cycle comparison against the model, plus a log of accepted writes.
  always @(negedge clock) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        cmp("we",    k, 64'(we[k]),   64'(m_pend[k]));
        cmp("addr",  k, 64'(addr[k]), 64'(m_ptr[k]));
        cmp("rows",  k, 64'(rows[k]), 64'(m_rows[k]));
        cmp("ovf",   k, 64'(ovf[k]),  64'(m_ovf[k]));
        cmp("done",  k, 64'(dn[k]),   64'(m_done[k]));
        if (we[k]) cmp("bus", k, 64'(bus[k]), 64'({m_hi[k], m_lo[k]}));
      end
      if (we[0] && WriteGrant1) log_a.push_back({addr[0], bus[0]});
      if (we[1] && WriteGrant1) log_b.push_back({addr[1], bus[1]});
    end
  end

  task automatic check_log(input string nm, input int k, input int idx,
                           input logic [56:0] exp);
    logic [56:0] got;
    got = '1;
    if (k == 0 && idx < log_a.size()) got = log_a[idx];
    if (k == 1 && idx < log_b.size()) got = log_b[idx];
    cmp(nm, k, 64'(got), 64'(exp));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    log_a.delete();
    log_b.delete();
  endtask

  task automatic send(input logic [23:0] v);
    sum_valid = 1'b1;
    row_sum   = v;
    step();
    sum_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset = 1'b1; start = 1'b0; sum_valid = 1'b0; row_sum = '0; WriteGrant1 = 1'b0;
    repeat (3) step();
    cmp("rst_we",   0, 64'(we[0]),   64'd0);
    cmp("rst_rows", 0, 64'(rows[0]), 64'd0);
    cmp("rst_done", 1, 64'(dn[1]),   64'd0);
    reset = 1'b0;
    step();

    // 1: four sums, grant tied high
    WriteGrant1 = 1'b1;
    pulse_start();
    for (int v = 1; v <= 4; v++) send(24'(v));
    repeat (8) step();
    check_log("t1_w0", 0, 0, {9'd0, 24'd2, 24'd1});
    check_log("t1_w1", 0, 1, {9'd1, 24'd4, 24'd3});
    cmp("t1_nwords", 0, 64'(log_a.size()), 64'd2);
    cmp("t1_done",   0, 64'(dn[0]),   64'd0);
    cmp("t1_rows",   0, 64'(rows[0]), 64'd4);
    cmp("t1_doneB",  1, 64'(dn[1]),   64'd1);

    // 2: odd tail on the NUM_ROWS=3 instance
    pulse_start();
    send(24'hABCDEF);
    send(24'h123456);
    send(24'h00FF00);
    for (int i = 0; i < 20 && !(we[1] && addr[1] == 9'd1); i++) step();
    cmp("t2_tail_we", 1, 64'(we[1] && addr[1] == 9'd1), 64'd1);
    cmp("t2_done_pre",  1, 64'(dn[1]), 64'd0);
    step();
    cmp("t2_done_post", 1, 64'(dn[1]), 64'd1);
    cmp("t2_rows",      1, 64'(rows[1]), 64'd3);
    check_log("t2_w0", 1, 0, {9'd0, 24'h123456, 24'hABCDEF});
    check_log("t2_w1", 1, 1, {9'd1, 24'h000000, 24'h00FF00});

    // 3: grant held low, seven back-to-back sums -> seventh dropped
    WriteGrant1 = 1'b0;
    pulse_start();
    for (int v = 1; v <= 7; v++) begin
      sum_valid = 1'b1;
      row_sum   = 24'(16 + v);
      step();
    end
    sum_valid = 1'b0;
    cmp("t3_ovf",   0, 64'(ovf[0]),  64'd1);
    cmp("t3_rows",  0, 64'(rows[0]), 64'd6);
    cmp("t3_ovfB",  1, 64'(ovf[1]),  64'd0);
    cmp("t3_rowsB", 1, 64'(rows[1]), 64'd3);

    // 4: request stable while stalled, then drains on grant
    for (int i = 0; i < 5; i++) begin
      step();
      cmp("t4_we",   0, 64'(we[0]),   64'd1);
      cmp("t4_addr", 0, 64'(addr[0]), 64'd0);
      cmp("t4_bus",  0, 64'(bus[0]),  64'({24'h000012, 24'h000011}));
    end
    WriteGrant1 = 1'b1;
    repeat (12) step();
    check_log("t4_w0", 0, 0, {9'd0, 24'h12, 24'h11});
    check_log("t4_w1", 0, 1, {9'd1, 24'h14, 24'h13});
    check_log("t4_w2", 0, 2, {9'd2, 24'h16, 24'h15});
    cmp("t4_nwords", 0, 64'(log_a.size()), 64'd3);

    // 5: sums after done are ignored; start re-arms
    cmp("t5_done", 1, 64'(dn[1]), 64'd1);
    send(24'h55);
    send(24'h56);
    step();
    cmp("t5_rows", 1, 64'(rows[1]), 64'd3);
    cmp("t5_ovf",  1, 64'(ovf[1]),  64'd0);
    pulse_start();
    cmp("t5_done_clr", 1, 64'(dn[1]),   64'd0);
    cmp("t5_rows_clr", 1, 64'(rows[1]), 64'd0);
    cmp("t5_addr_clr", 1, 64'(addr[1]), 64'd0);
    send(24'h7);
    send(24'h8);
    repeat (6) step();
    check_log("t5_w0", 1, 0, {9'd0, 24'h8, 24'h7});

    // 6: asynchronous reset in the middle of a pending write
    WriteGrant1 = 1'b0;
    pulse_start();
    send(24'h21);
    send(24'h22);
    for (int i = 0; i < 10 && !we[0]; i++) step();
    cmp("t6_pend", 0, 64'(we[0]), 64'd1);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      cmp("t6_we",   k, 64'(we[k]),   64'd0);
      cmp("t6_addr", k, 64'(addr[k]), 64'd0);
      cmp("t6_bus",  k, 64'(bus[k]),  64'd0);
      cmp("t6_rows", k, 64'(rows[k]), 64'd0);
      cmp("t6_ovf",  k, 64'(ovf[k]),  64'd0);
      cmp("t6_done", k, 64'(dn[k]),   64'd0);
    end
    step();
    reset = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
